freq_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square-wave input in cycles of the fast system clock. It is the receive-side counterpart of the clock divider: it checks a divided clock, or any slow external signal, against the 100 MHz clock. Results go to the display/checker logic as one-cycle valid pulses with held values. A sticky timeout flags a missing or stalled input.

---
 rtl/freq_meter.sv | 136 +++++++++++++
 tb/tb_freq_meter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Period and high-time meter for a slow asynchronous square wave, counted in clk cycles.
// Results are presented as held values with a one-cycle meas_valid strobe; timeout is sticky.
module freq_meter #(
  parameter int CNT_WIDTH = 27,
  parameter int TIMEOUT   = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state_reg, state_next;

  logic sync1_reg, sync2_reg, sig_d_reg;
  logic rise, fall;

  logic [CNT_WIDTH-1:0] per_cnt_reg, per_cnt_next;
  logic [CNT_WIDTH-1:0] hi_cap_reg, hi_cap_next;
  logic [CNT_WIDTH-1:0] period_reg, period_next;
  logic [CNT_WIDTH-1:0] high_time_reg, high_time_next;
  logic                 meas_valid_reg, meas_valid_next;
  logic                 timeout_reg, timeout_next;

  // Two-flop synchronizer plus one delay stage for edge detection; free-running in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sig_d_reg <= 1'b0;
    end else begin
      sync1_reg <= sig_in;
      sync2_reg <= sync1_reg;
      sig_d_reg <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~sig_d_reg;
  assign fall = ~sync2_reg & sig_d_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      per_cnt_reg    <= '0;
      hi_cap_reg     <= '0;
      period_reg     <= '0;
      high_time_reg  <= '0;
      meas_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      per_cnt_reg    <= per_cnt_next;
      hi_cap_reg     <= hi_cap_next;
      period_reg     <= period_next;
      high_time_reg  <= high_time_next;
      meas_valid_reg <= meas_valid_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    per_cnt_next    = per_cnt_reg;
    hi_cap_next     = hi_cap_reg;
    period_next     = period_reg;
    high_time_next  = high_time_reg;
    meas_valid_next = 1'b0;
    timeout_next    = timeout_reg;

    case (state_reg)
      IDLE: begin
        per_cnt_next = '0;
        hi_cap_next  = '0;
        if (enable) begin
          state_next = ARM;
        end
      end

      ARM: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (rise) begin
          per_cnt_next = CNT_ONE;
          state_next   = MEASURE;
        end
      end

      MEASURE: begin
        // Rise beats the timeout check, so a period of exactly TIMEOUT is still reported.
        if (!enable) begin
          state_next = IDLE;
        end else if (rise) begin
          period_next     = per_cnt_reg;
          high_time_next  = hi_cap_reg;
          meas_valid_next = 1'b1;
          timeout_next    = 1'b0;
          per_cnt_next    = CNT_ONE;
        end else if (per_cnt_reg == TIMEOUT_CNT) begin
          timeout_next   = 1'b1;
          period_next    = '0;
          high_time_next = '0;
          per_cnt_next   = '0;
          state_next     = ARM;
        end else begin
          per_cnt_next = per_cnt_reg + CNT_ONE;
          if (fall) begin
            hi_cap_next = per_cnt_reg;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign meas_valid = meas_valid_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: an edge-time model predicts reports and timeouts,
// a negedge monitor matches every meas_valid / timeout assertion against the expected queue.
module tb_freq_meter;

  localparam int CW = 12;
  localparam int TO = 1000;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;

  freq_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected events; stamp is the bench cycle at whose negedge the event must be visible.
  typedef struct {
    bit is_tmo;
    int per;
    int hi;
    int stamp;
  } exp_t;
  exp_t q[$];

  // Model in detected-edge time: 0 = disabled, 1 = waiting for first rise, 2 = measuring.
  int m_state = 0;
  int m_arm_from = 0;
  int m_last = 0;
  int m_hi = 0;
  bit m_tmo = 0;

  function automatic void push_exp(bit t, int p, int h, int s);
    exp_t e;
    e.is_tmo = t;
    e.per    = p;
    e.hi     = h;
    e.stamp  = s;
    q.push_back(e);
  endfunction

  // slack=1 when the event at time t would itself win against an expiring count.
  function automatic void m_advance(int t, int slack);
    if (m_state == 2 && (t - m_last) >= TO + slack) begin
      if (!m_tmo) push_exp(1'b1, 0, 0, m_last + TO);
      m_tmo      = 1'b1;
      m_state    = 1;
      m_arm_from = m_last + TO + 1;
    end
  endfunction

  function automatic void m_rise(int t);
    m_advance(t, 1);
    if (m_state == 2) begin
      push_exp(1'b0, t - m_last, m_hi, t);
      m_tmo  = 1'b0;
      m_last = t;
    end else if (m_state == 1 && t >= m_arm_from) begin
      m_state = 2;
      m_last  = t;
    end
  endfunction

  function automatic void m_fall(int t);
    m_advance(t, 0);
    if (m_state == 2) m_hi = t - m_last;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the synchronizer makes the edge act at the third following posedge.
  task automatic drive_sig(input logic v);
    sig_in = v;
    if (v) m_rise(cyc + 3);
    else   m_fall(cyc + 3);
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    if (v) begin
      if (m_state == 0) begin
        m_state    = 1;
        m_arm_from = cyc + 2;
      end
    end else begin
      m_advance(cyc + 1, 1);
      m_state = 0;
      m_hi    = 0;
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      drive_sig(1'b1);
      m_advance(cyc + 3 + hi, 0);
      wait_cyc(hi);
      drive_sig(1'b0);
      m_advance(cyc + 3 + per - hi, 1);
      wait_cyc(per - hi);
    end
  endtask

  // Monitor: every report or timeout assertion must match the head of the queue,
  // and between events all outputs must hold.
  initial begin : monitor
    exp_t e;
    int   hold_per;
    int   hold_hi;
    bit   prev_tmo;
    hold_per = 0;
    hold_hi  = 0;
    prev_tmo = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_per = 0;
        hold_hi  = 0;
        prev_tmo = 1'b0;
      end else begin
        if (meas_valid || (timeout && !prev_tmo)) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event at cycle %0d: meas_valid=%0b timeout=%0b period=%0d high_time=%0d, expected none",
                     cyc, meas_valid, timeout, period, high_time);
          end else begin
            e = q.pop_front();
            chk("event_time", cyc, e.stamp);
            chk("event_kind_meas_valid", int'(meas_valid), e.is_tmo ? 0 : 1);
            chk("event_kind_timeout", int'(timeout), e.is_tmo ? 1 : 0);
            chk("period", int'(period), e.per);
            chk("high_time", int'(high_time), e.hi);
            $display("[TB] cycle %0d %s period=%0d high_time=%0d (expected %0d/%0d)",
                     cyc, e.is_tmo ? "timeout" : "measure", period, high_time, e.per, e.hi);
          end
          hold_per = int'(period);
          hold_hi  = int'(high_time);
        end else begin
          while (q.size() > 0 && q[0].stamp < cyc) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_event: nothing seen at cycle %0d, expected %s period=%0d high_time=%0d",
                     e.stamp, e.is_tmo ? "timeout" : "measure", e.per, e.hi);
          end
          chk("hold_period", int'(period), hold_per);
          chk("hold_high_time", int'(high_time), hold_hi);
          chk("hold_timeout", int'(timeout), int'(prev_tmo));
        end
        prev_tmo = timeout;
      end
    end
  end

  initial begin : stim
    int per;
    int hi;
    reset  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    wait_cyc(5);
    chk("reset_period", int'(period), 0);
    chk("reset_high_time", int'(high_time), 0);
    chk("reset_meas_valid", int'(meas_valid), 0);
    chk("reset_timeout", int'(timeout), 0);
    reset = 1'b1;
    wait_cyc(5);

    // Steady wave, then a duty/period change.
    set_enable(1'b1);
    wait_cyc(10);
    wave(100, 40, 5);
    wave(250, 10, 3);

    // Random periods, all shorter than the timeout.
    for (int i = 0; i < 8; i++) begin
      per = $urandom_range(900, 20);
      hi  = $urandom_range(per - 2, 2);
      wave(per, hi, 2);
    end

    // Stall, then recovery.
    m_advance(cyc + 3 + 1500, 0);
    wait_cyc(1500);
    wave(100, 40, 3);

    // Timeout boundary: 1000 is reported, 1001 times out.
    wave(1000, 500, 2);
    wave(1001, 500, 2);
    wave(100, 40, 3);

    // Enable dropped 30 cycles into a period, wave continues while disabled.
    wave(100, 40, 2);
    drive_sig(1'b1);
    wait_cyc(30);
    set_enable(1'b0);
    wait_cyc(10);
    drive_sig(1'b0);
    wait_cyc(60);
    wave(100, 40, 2);
    set_enable(1'b1);
    wait_cyc(20);
    wave(100, 40, 3);

    // Asynchronous reset between clock edges during the low phase.
    wave(150, 60, 2);
    drive_sig(1'b1);
    wait_cyc(40);
    drive_sig(1'b0);
    wait_cyc(20);
    @(posedge clk);
    #2;
    reset = 1'b0;
    m_state = 0;
    m_hi    = 0;
    m_tmo   = 1'b0;
    #1;
    chk("async_reset_period", int'(period), 0);
    chk("async_reset_high_time", int'(high_time), 0);
    chk("async_reset_meas_valid", int'(meas_valid), 0);
    chk("async_reset_timeout", int'(timeout), 0);
    @(negedge clk);
    wait_cyc(3);
    reset = 1'b1;
    m_state    = 1;
    m_arm_from = cyc + 2;
    wait_cyc(10);
    wave(120, 30, 3);

    wait_cyc(50);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
